instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
- Sequences the program ROM: owns the PC register and drives the ROM's combinational read address.
- Captures {PC, instruction} pairs into a 2-entry prefetch buffer and presents them to the decode stage with a valid/ready handshake.
- Handles branch/jump redirects, stalls and address faults.
- Sits between the Program_Memory instance and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset; also the ROM base address.
- MEM_WORDS, 32, ROM depth in 32-bit words; legal PC range is RESET_PC to RESET_PC+4*MEM_WORDS-4.
- DATA_WIDTH, 32, PC and instruction width.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- enable_i, input, 1, fetch enable; low means no new fetches, buffer still drains.
- redirect_i, input, 1, branch/jump taken; one-cycle pulse.
- redirect_pc_i, input, 32, redirect target address.
- Instruction_i, input, 32, ROM read data for the current Address_o (same cycle).
- Address_o, output, 32, PC driven to the ROM; equals pc_q.
- valid_o, output, 1, buffer head holds a valid entry.
- ready_i, input, 1, decode stage accepts the head entry this cycle.
- pc_o, output, 32, PC of the head entry.
- instr_o, output, 32, instruction of the head entry.
- fault_o, output, 1, sticky fault flag.
- fault_cause_o, output, 2, 00 none, 01 misaligned redirect, 10 PC out of range.

Behaviour:
- Reset (async): pc_q=RESET_PC, buffer count=0, valid_o=0, pc_o=0, instr_o=0, fault_o=0, fault_cause_o=00, state=IDLE.
- States:
  - IDLE: no fetch; always moves to RUN on the next edge.
  - RUN: normal fetching.
  - HALT: no fetch; buffer drains; leaves only on a legal redirect.
- Pop: occurs when valid_o and ready_i are both high. The head advances at the edge.
- Push in RUN: occurs when enable_i=1, redirect_i=0, pc_q is in range, and either count<2 or a pop happens this cycle.
  - Writes {pc_q, Instruction_i} to the tail.
  - pc_q <= pc_q+4 (mod 2^32).
- Full buffer (count=2) with no pop: no push; pc_q holds; Address_o is stable.
- Simultaneous push and pop: count is unchanged; the entry order is preserved.
- Latency: reset release, then IDLE for 1 cycle, then the first push at the 2nd edge. valid_o rises after the 2nd edge, with pc_o=RESET_PC.
- Redirect (highest priority, any state):
  - The buffer is cleared (count=0 after the edge). A pop in the same cycle is still a completed handshake.
  - No push that cycle.
  - If redirect_pc_i[1:0]!=0: fault_o=1, cause=01, state=HALT, pc_q unchanged.
  - If redirect_pc_i is out of range: fault_o=1, cause=10, state=HALT.
  - Otherwise: pc_q=redirect_pc_i, fault_o=0, cause=00, state=RUN. This is the only way to clear a fault.
  - The first redirected entry is valid 1 cycle after the redirect edge.
- Range check in RUN: if pc_q is out of range (e.g. sequential fetch past the last word), there is no push. At the edge: fault_o=1, cause=10, state=HALT. Entries already buffered still drain normally.
- Range check arithmetic: offset=pc_q-RESET_PC as unsigned 32-bit. The PC is in range iff offset[1:0]==0 and offset[31:2]<MEM_WORDS. Wrap below RESET_PC yields a large offset, so it is out of range.
- enable_i=0 in RUN: no push, pc_q holds, the state stays RUN.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight entries are discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds three 32-bit output ports, all reset to 0 and wrapping at 2^32:
  - fetch_cnt_o: increments on each push.
  - stall_cnt_o: increments on each cycle in RUN with enable_i=1 where the push is blocked by a full buffer.
  - flush_cnt_o: increments on each redirect that discards at least 1 buffered entry.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with ready_i=1, enable_i=1 -> valid_o rises after the 2nd edge; pc_o=0x00400000, then 0x00400004, 0x00400008 on consecutive cycles; each instr_o matches the ROM word.
- ready_i=0 for 5 cycles -> count saturates at 2; Address_o holds at 0x00400008. Raising ready_i delivers 0x00400000, 0x00400004, 0x00400008 in order, with no drop or duplicate.
- Redirect to 0x00400040 with the buffer full -> buffer flushed; the next valid pc_o=0x00400040 one cycle later; fault_o=0.
- Redirect to 0x00400042 -> fault_o=1, cause=01, no further pushes. Then redirect to 0x00400010 -> fault cleared; pc_o=0x00400010.
- Sequential run to 0x0040007C (last word, MEM_WORDS=32) -> that entry is delivered; next cycle fault_o=1, cause=10; valid_o falls after the drain.
- Assert reset mid-stream with count=2 -> valid_o=0 and Address_o=0x00400000 immediately, before the next clock edge.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Purpose : program ROM sequencer; owns the PC and feeds {pc, instr} pairs through a 2-entry prefetch buffer to decode.
// Latency : the first entry is valid after the 2nd edge out of reset, and 1 cycle after a redirect edge.
// Backpr. : valid/ready toward decode; with the buffer full and no pop, fetch stalls and Address_o holds.
//
// Ports:
//   clk, reset (async, active-high)
//   enable_i                      fetch enable (the buffer still drains when low)
//   redirect_i, redirect_pc_i     branch/jump redirect pulse and its target
//   Address_o, Instruction_i      combinational ROM read port (Address_o == pc_q)
//   valid_o, ready_i, pc_o, instr_o   head of the prefetch buffer toward decode
//   fault_o, fault_cause_o        sticky fault (01 misaligned redirect, 10 PC out of range)
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt_o, stall_cnt_o and flush_cnt_o.
module instr_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter int                    MEM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  fault_o,
    output logic [1:0]            fault_cause_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic                    fault_q, fault_d;
    logic [1:0]              cause_q, cause_d;

    logic [DATA_WIDTH-1:0]   buf_pc  [2];
    logic [DATA_WIDTH-1:0]   buf_ins [2];
    logic                    rd_ptr, wr_ptr;
    logic [1:0]              count;

    logic                    pop, push, pc_ok;

    // Offset from the ROM base, unsigned: anything below the base wraps to a huge offset.
    function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] off;
        off = a - RESET_PC;
        return (off[1:0] == 2'b00) &&
               ({2'b00, off[DATA_WIDTH-1:2]} < DATA_WIDTH'(MEM_WORDS));
    endfunction

    assign pc_ok = in_range(pc_q);
    assign pop   = (count != 2'd0) && ready_i;
    // A full buffer can still accept when its head leaves in the same cycle.
    assign push  = (state_q == RUN) && enable_i && !redirect_i && pc_ok &&
                   ((count != 2'd2) || pop);

    assign Address_o     = pc_q;
    assign valid_o       = (count != 2'd0);
    assign pc_o          = buf_pc[rd_ptr];
    assign instr_o       = buf_ins[rd_ptr];
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        cause_d = cause_q;
        if (redirect_i) begin
            // Redirect wins in every state and is the only way out of HALT.
            if (redirect_pc_i[1:0] != 2'b00) begin
                fault_d = 1'b1;
                cause_d = 2'b01;
                state_d = HALT;
            end else if (!in_range(redirect_pc_i)) begin
                fault_d = 1'b1;
                cause_d = 2'b10;
                state_d = HALT;
            end else begin
                pc_d    = redirect_pc_i;
                fault_d = 1'b0;
                cause_d = 2'b00;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (!pc_ok) begin
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                        state_d = HALT;
                    end else if (push) begin
                        pc_d = pc_q + DATA_WIDTH'(4);
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]  <= '0;
                buf_ins[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect_i) begin
            // Flush; a concurrent pop already completed its handshake.
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]  <= pc_q;
                buf_ins[wr_ptr] <= Instruction_i;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall, flush;
    assign stall = (state_q == RUN) && enable_i && !redirect_i && pc_ok &&
                   (count == 2'd2) && !pop;
    // Only count flushes that actually discard something left behind after a pop.
    assign flush = redirect_i && (count > {1'b0, pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (push)  fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (stall) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule
